sync_fifo_ctrl: RTL

- Single-clock, parametrised FIFO; next generation of the team's FIFO buffer.
- Generalised width, depth and read-data mode, with behaviour the previous FIFO lacks:
  - real full/empty flags
  - fill level and almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
- Used as the elastic buffer between producer/consumer pipeline stages sharing one clock.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_mem.sv | 34 +++
 rtl/sync_fifo_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: address-width helper, default
// pointer type and reset values for the registered status/output state.
// No logic; imported by sync_fifo_ctrl.
package sync_fifo_pkg;

   // Address width for a given depth. Depth is a power of two >= 2, so this
   // is at least 1 and an (ADDR_WIDTH+1)-bit pointer wraps modulo 2*DEPTH.
   function automatic int fifo_addr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Default configuration and its pointer type. Parametrised instances
   // derive their own pointer type from fifo_addr_width(DEPTH).
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_ADDR_WIDTH = fifo_addr_width(DEF_DEPTH);
   typedef logic [DEF_ADDR_WIDTH:0] fifo_ptr_t;

   // Reset values of the registered state.
   localparam logic RST_RVALID = 1'b0;
   localparam logic RST_ERR    = 1'b0;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the FIFO: one write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational from raddr_i.
// Backpressure: none; the controller only asserts we_i for accepted writes.
//
// Ports:
//   clk_i            write clock
//   we_i             write enable (already qualified by the controller)
//   waddr_i/wdata_i  write address / data
//   raddr_i/rdata_o  read address / data
// Contents are deliberately not reset so the array can be replaced by a macro.
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock parametrised FIFO with level, almost flags and sticky errors.
// Latency: 1 cycle read data when RDATA_REG=1, first-word-fall-through when 0.
// Backpressure: writes dropped while full (overflow), reads while empty (underflow).
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   wen_i, wdata_i             write request and data
//   ren_i                      read request
//   clr_err_i                  clears overflow_o / underflow_o
//   rdata_o, rvalid_o          read data and its qualifier
//   full_o, empty_o            occupancy flags
//   almost_full_o/empty_o      threshold flags against level_o
//   level_o                    entry count 0..DEPTH
//   overflow_o, underflow_o    sticky error flags
module sync_fifo_ctrl
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 16,
   parameter int RDATA_REG     = 1,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          wen_i,
   input  logic [DATA_WIDTH-1:0]         wdata_i,
   input  logic                          ren_i,
   input  logic                          clr_err_i,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          rvalid_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic                          almost_full_o,
   output logic                          almost_empty_o,
   output logic [$clog2(DEPTH):0]        level_o,
   output logic                          overflow_o,
   output logic                          underflow_o
);

   localparam int ADDR_WIDTH = fifo_addr_width(DEPTH);

   typedef logic [ADDR_WIDTH:0] ptr_t;

   // Thresholds sized to the level width; both lie in 0..DEPTH so they fit.
   localparam ptr_t AFULL_T  = ptr_t'(AFULL_THRESH);
   localparam ptr_t AEMPTY_T = ptr_t'(AEMPTY_THRESH);

   ptr_t                  r_wptr;
   ptr_t                  r_rptr;
   logic                  r_ovf;
   logic                  r_unf;

   ptr_t                  w_level;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_acc_wr;
   logic                  w_acc_rd;
   logic                  w_mem_we;
   logic [DATA_WIDTH-1:0] w_mem_rdata;

   // Status is decoded purely from the registered pointers, so no request
   // input reaches a flag combinationally. The extra pointer bit tells a
   // full FIFO (MSBs differ) from an empty one (pointers identical), and the
   // modulo-2*DEPTH difference is exactly the fill level 0..DEPTH.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                    (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
   assign w_level = r_wptr - r_rptr;

   assign w_acc_wr = wen_i && !w_full;
   assign w_acc_rd = ren_i && !w_empty;

   // A request in the reset cycle must not touch the array either.
   assign w_mem_we = w_acc_wr && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_acc_wr) begin
            r_wptr <= r_wptr + ptr_t'(1);
         end
         if (w_acc_rd) begin
            r_rptr <= r_rptr + ptr_t'(1);
         end
      end
   end

   // Sticky errors: a new error in the same cycle as a clear wins, so an
   // event is never lost to a coincident clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ovf <= RST_ERR;
         r_unf <= RST_ERR;
      end else begin
         if (wen_i && w_full) begin
            r_ovf <= 1'b1;
         end else if (clr_err_i) begin
            r_ovf <= 1'b0;
         end
         if (ren_i && w_empty) begin
            r_unf <= 1'b1;
         end else if (clr_err_i) begin
            r_unf <= 1'b0;
         end
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (w_mem_we),
      .waddr_i (r_wptr[ADDR_WIDTH-1:0]),
      .wdata_i (wdata_i),
      .raddr_i (r_rptr[ADDR_WIDTH-1:0]),
      .rdata_o (w_mem_rdata)
   );

   generate
      if (RDATA_REG != 0) begin : g_rdata_reg
         logic [DATA_WIDTH-1:0] r_rdata;
         logic                  r_rvalid;

         // Capture the head word on an accepted read; rvalid is a one-cycle
         // pulse and rdata holds until the next accepted read.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_rdata  <= '0;
               r_rvalid <= RST_RVALID;
            end else begin
               r_rvalid <= w_acc_rd;
               if (w_acc_rd) begin
                  r_rdata <= w_mem_rdata;
               end
            end
         end

         assign rdata_o  = r_rdata;
         assign rvalid_o = r_rvalid;
      end else begin : g_rdata_fwft
         // Head of queue is always presented; valid whenever not empty.
         assign rdata_o  = w_mem_rdata;
         assign rvalid_o = !w_empty;
      end
   endgenerate

   assign full_o         = w_full;
   assign empty_o        = w_empty;
   assign level_o        = w_level;
   assign almost_full_o  = (w_level >= AFULL_T);
   assign almost_empty_o = (w_level <= AEMPTY_T);
   assign overflow_o     = r_ovf;
   assign underflow_o    = r_unf;

endmodule
